line_formatter: RTL

LINE_FORMATTER -- requirements
Module: line_formatter

---
 rtl/fmt_pkg.sv | 17 +
 rtl/fmt_fifo.sv | 47 ++++
 rtl/line_formatter.sv | 97 +++++++++
 3 files changed

// File: rtl/fmt_pkg.sv
// fmt_pkg: shared constants, FIFO entry type and byte-formatting helper for line_formatter
package fmt_pkg;
   localparam logic [7:0] MARKER     = 8'hFF;
   localparam logic [7:0] MARKER_SUB = 8'hFE;
   localparam int         WORD_W     = 16;

   typedef struct packed {
      logic              is_marker;
      logic [WORD_W-1:0] word;
   } fmt_entry_t;

   function automatic logic [7:0] ent_byte(input fmt_entry_t e, input logic idx);
      logic [7:0] b;
      b = idx ? e.word[7:0] : e.word[15:8];
      return e.is_marker ? MARKER : (b == MARKER ? MARKER_SUB : b);
   endfunction
endpackage

// File: rtl/fmt_fifo.sv
// fmt_fifo: synchronous FIFO exposing the head and the entry behind it for bubble-free reads
module fmt_fifo
   import fmt_pkg::*;
#(
   parameter int DEPTH = 16
) (
   input  logic       i_clk,
   input  logic       i_rst,
   input  logic       i_wr_en,
   input  fmt_entry_t i_wr_data,
   input  logic       i_rd_en,
   output fmt_entry_t o_rd_data,
   output fmt_entry_t o_rd_nx,
   output logic       o_full,
   output logic       o_empty,
   output logic       o_two
);
   localparam int AW = $clog2(DEPTH);

   fmt_entry_t      r_mem [DEPTH];
   logic [AW:0]     r_wptr, r_rptr;
   logic [AW:0]     w_cnt, w_rnx;

   assign w_cnt     = r_wptr - r_rptr;
   assign w_rnx     = r_rptr + 1'b1;
   assign o_full    = w_cnt == (AW+1)'(DEPTH);
   assign o_empty   = w_cnt == '0;
   assign o_two     = w_cnt > (AW+1)'(1);
   assign o_rd_data = r_mem[r_rptr[AW-1:0]];
   assign o_rd_nx   = r_mem[w_rnx[AW-1:0]];

   // pointers: writes into a full FIFO are dropped, reads only happen when non-empty
   always_ff @(posedge i_clk or posedge i_rst) begin
      if (i_rst) begin
         r_wptr <= '0;
         r_rptr <= '0;
      end else begin
         if (i_wr_en && !o_full) r_wptr <= r_wptr + 1'b1;
         if (i_rd_en && !o_empty) r_rptr <= r_rptr + 1'b1;
      end
   end

   // storage array, no reset needed since pointers gate visibility
   always_ff @(posedge i_clk) begin
      if (i_wr_en && !o_full) r_mem[r_wptr[AW-1:0]] <= i_wr_data;
   end
endmodule

// File: rtl/line_formatter.sv
// line_formatter: buffers pixel lines and serialises them into an escaped byte stream with EOL markers
module line_formatter
   import fmt_pkg::*;
#(
   parameter int IN_W       = 16,
   parameter int OUT_BYTES  = 1,
   parameter int FIFO_DEPTH = 16,
   parameter int LEN_W      = 16
) (
   input  logic             rx_clk,
   input  logic             rst,
   input  logic             rx_valid,
   input  logic [IN_W-1:0]  rx_data,
   input  logic             tx_ready,
   output logic             tx_valid,
   output logic [7:0]       tx_data,
   output logic [LEN_W-1:0] line_len,
   output logic             ovf,
   input  logic             ovf_clr
);
   localparam int   PW     = 8*OUT_BYTES;
   localparam logic L_LAST = (OUT_BYTES == 2);

   logic             r_rx_valid_d, r_tx_valid, r_idx, r_ovf;
   logic [7:0]       r_tx_data;
   logic [LEN_W-1:0] r_cnt, r_line_len;
   logic [WORD_W-1:0] w_word;
   fmt_entry_t       w_wr_data, w_head, w_nx;
   logic             w_wr_en, w_full, w_empty, w_two, w_rd_en;
   logic             w_xfer, w_last, w_nx_valid, w_nx_idx;
   logic [7:0]       w_nx_data;

   assign w_word    = WORD_W'(rx_data[IN_W-1 -: PW]) << (WORD_W - PW);
   assign w_wr_en   = rx_valid | r_rx_valid_d;
   assign w_wr_data = rx_valid ? fmt_entry_t'{1'b0, w_word} : fmt_entry_t'{1'b1, '0};

   fmt_fifo #(.DEPTH(FIFO_DEPTH)) u_fifo (
      .i_clk     (rx_clk),
      .i_rst     (rst),
      .i_wr_en   (w_wr_en),
      .i_wr_data (w_wr_data),
      .i_rd_en   (w_rd_en),
      .o_rd_data (w_head),
      .o_rd_nx   (w_nx),
      .o_full    (w_full),
      .o_empty   (w_empty),
      .o_two     (w_two)
   );

   // output register tracks the head byte; on the final byte's transfer it preloads the next entry
   always_comb begin
      w_xfer     = r_tx_valid & tx_ready;
      w_last     = w_head.is_marker | (r_idx == L_LAST);
      w_rd_en    = w_xfer & w_last;
      w_nx_valid = w_xfer ? (!w_last | w_two) : (r_tx_valid | !w_empty);
      w_nx_data  = w_xfer ? (w_last ? (w_two ? ent_byte(w_nx, 1'b0) : r_tx_data)
                                    : ent_byte(w_head, r_idx + 1'b1))
                          : ((r_tx_valid | w_empty) ? r_tx_data : ent_byte(w_head, 1'b0));
      w_nx_idx   = w_xfer ? (w_last ? 1'b0 : r_idx + 1'b1) : r_idx;
   end

   // registered output handshake state
   always_ff @(posedge rx_clk or posedge rst) begin
      if (rst) begin
         r_tx_valid <= 1'b0;
         r_tx_data  <= '0;
         r_idx      <= 1'b0;
      end else begin
         r_tx_valid <= w_nx_valid;
         r_tx_data  <= w_nx_data;
         r_idx      <= w_nx_idx;
      end
   end

   // line tracking: saturating pixel count latched into line_len on the marker edge, sticky overflow
   always_ff @(posedge rx_clk or posedge rst) begin
      if (rst) begin
         r_rx_valid_d <= 1'b0;
         r_cnt        <= '0;
         r_line_len   <= '0;
         r_ovf        <= 1'b0;
      end else begin
         r_rx_valid_d <= rx_valid;
         if (rx_valid) r_cnt <= &r_cnt ? r_cnt : r_cnt + 1'b1;
         else if (r_rx_valid_d) begin
            r_line_len <= r_cnt;
            r_cnt      <= '0;
         end
         r_ovf <= (w_wr_en & w_full) ? 1'b1 : (ovf_clr ? 1'b0 : r_ovf);
      end
   end

   assign tx_valid = r_tx_valid;
   assign tx_data  = r_tx_data;
   assign line_len = r_line_len;
   assign ovf      = r_ovf;
endmodule
